// File: rtl/row_mac_unit.sv
// Row multiply-accumulate responder.
// On a begin_mult request, reads NCOL coefficients for the requested row, forms
// the signed dot product with the held input vector, writes it to the result
// buffer and answers with a one-cycle done_row pulse.
module row_mac_unit #(
    parameter int unsigned NROW = 10,
    parameter int unsigned NCOL = 8,
    parameter int unsigned DW   = 16,
    parameter int unsigned ACCW = 2 * DW + $clog2(NCOL)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         begin_mult,
    input  logic [3:0]                   res_add,
    input  logic [NCOL*DW-1:0]           vec_data,
    output logic                         coef_rd,
    output logic [4+$clog2(NCOL)-1:0]    coef_addr,
    input  logic [DW-1:0]                coef_rdata,
    output logic                         res_wr,
    output logic [3:0]                   res_waddr,
    output logic [ACCW-1:0]              res_wdata,
    output logic                         done_row,
    output logic                         bad_row
);

    localparam int unsigned CW = $clog2(NCOL);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRun   = 3'd1;
    localparam logic [2:0] StDrain = 3'd2;
    localparam logic [2:0] StWrite = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [3:0]         row_q, row_d;
    logic [CW-1:0]      col_q, col_d;
    logic [ACCW-1:0]    acc_q, acc_d;
    logic               coef_rd_q, coef_rd_d;
    logic [4+CW-1:0]    coef_addr_q, coef_addr_d;
    logic               res_wr_q, res_wr_d;
    logic [3:0]         res_waddr_q, res_waddr_d;
    logic [ACCW-1:0]    res_wdata_q, res_wdata_d;
    logic               done_q, done_d;
    logic               bad_q, bad_d;

    logic signed [DW-1:0]   vec_elem [NCOL];
    logic [CW-1:0]          mac_col;
    logic signed [2*DW-1:0] prod;
    logic [ACCW-1:0]        prod_ext;
    logic [ACCW-1:0]        acc_sum;

    // Unpack the vector into signed elements
    always_comb begin
        for (int k = 0; k < NCOL; k++) begin
            vec_elem[k] = vec_data[k*DW +: DW];
        end
    end

    // Coefficient data lags its read by one cycle, so it pairs with the previous column;
    // in DRAIN the column counter already sits on the last column.
    always_comb begin
        mac_col  = (state_q == StDrain) ? col_q : col_q - CW'(1);
        prod     = $signed(coef_rdata) * vec_elem[mac_col];
        prod_ext = {{(ACCW - 2 * DW){prod[2*DW-1]}}, prod};
        acc_sum  = acc_q + prod_ext;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        acc_d       = acc_q;
        coef_rd_d   = coef_rd_q;
        coef_addr_d = coef_addr_q;
        res_wr_d    = 1'b0;
        res_waddr_d = res_waddr_q;
        res_wdata_d = res_wdata_q;
        done_d      = 1'b0;
        bad_d       = 1'b0;

        case (state_q)
            StIdle: begin
                if (begin_mult) begin
                    row_d = res_add;
                    col_d = '0;
                    acc_d = '0;
                    if (32'(res_add) < NROW) begin
                        state_d     = StRun;
                        coef_rd_d   = 1'b1;
                        coef_addr_d = {res_add, CW'(0)};
                    end else begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        bad_d   = 1'b1;
                    end
                end
            end
            StRun: begin
                if (col_q != '0) begin
                    acc_d = acc_sum;
                end
                if (col_q == CW'(NCOL - 1)) begin
                    state_d   = StDrain;
                    coef_rd_d = 1'b0;
                end else begin
                    col_d       = col_q + CW'(1);
                    coef_addr_d = {row_q, col_q + CW'(1)};
                end
            end
            StDrain: begin
                acc_d       = acc_sum;
                res_wr_d    = 1'b1;
                res_waddr_d = row_q;
                res_wdata_d = acc_sum;
                state_d     = StWrite;
            end
            StWrite: begin
                done_d  = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                // Always return to IDLE so begin_mult is resampled after the controller advances
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            row_q       <= '0;
            col_q       <= '0;
            acc_q       <= '0;
            coef_rd_q   <= 1'b0;
            coef_addr_q <= '0;
            res_wr_q    <= 1'b0;
            res_waddr_q <= '0;
            res_wdata_q <= '0;
            done_q      <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            acc_q       <= acc_d;
            coef_rd_q   <= coef_rd_d;
            coef_addr_q <= coef_addr_d;
            res_wr_q    <= res_wr_d;
            res_waddr_q <= res_waddr_d;
            res_wdata_q <= res_wdata_d;
            done_q      <= done_d;
            bad_q       <= bad_d;
        end
    end

    assign coef_rd   = coef_rd_q;
    assign coef_addr = coef_addr_q;
    assign res_wr    = res_wr_q;
    assign res_waddr = res_waddr_q;
    assign res_wdata = res_wdata_q;
    assign done_row  = done_q;
    assign bad_row   = bad_q;

endmodule

// File: tb/tb_row_mac_unit.sv
// Scoreboard bench for row_mac_unit: stimulus pushes expected writes/done pulses,
// a negedge monitor pops and compares them as the DUT presents them.
// Timing note: a value seen at the negedge with cyc==n is the one a downstream
// block samples at rising edge n+1; T is the edge where IDLE samples begin_mult.
module tb_row_mac_unit;

    localparam int NROW = 10;
    localparam int NCOL = 8;
    localparam int DW   = 16;
    localparam int ACCW = 35;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  begin_mult;
    logic [3:0]            res_add;
    logic [NCOL*DW-1:0]    vec_data;
    logic                  coef_rd;
    logic [6:0]            coef_addr;
    logic [DW-1:0]         coef_rdata = '0;
    logic                  res_wr;
    logic [3:0]            res_waddr;
    logic [ACCW-1:0]       res_wdata;
    logic                  done_row;
    logic                  bad_row;

    row_mac_unit dut (
        .clk        (clk),
        .reset      (reset),
        .begin_mult (begin_mult),
        .res_add    (res_add),
        .vec_data   (vec_data),
        .coef_rd    (coef_rd),
        .coef_addr  (coef_addr),
        .coef_rdata (coef_rdata),
        .res_wr     (res_wr),
        .res_waddr  (res_waddr),
        .res_wdata  (res_wdata),
        .done_row   (done_row),
        .bad_row    (bad_row)
    );

    always #5 clk = ~clk;

    // Coefficient memory (16 rows x NCOL) and input vector
    logic signed [DW-1:0] coef_mem [128];
    logic signed [DW-1:0] vec [NCOL];

    always_comb begin
        for (int k = 0; k < NCOL; k++) vec_data[k*DW +: DW] = vec[k];
    end

    always @(posedge clk) if (coef_rd) coef_rdata <= coef_mem[coef_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [63:0] data;
    } exp_wr_t;

    exp_wr_t     exp_wr [$];
    logic        exp_bad [$];
    exp_wr_t     mon_wr;
    logic        mon_bad;

    int          wr_count = 0;
    int          done_count = 0;
    int          rd_count = 0;
    int          last_wr_cyc = -1;
    logic [3:0]  last_waddr = '0;
    logic [63:0] last_wdata = '0;
    int          rd_cyc [$];
    logic [6:0]  rd_addr [$];
    logic        prev_done = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, $signed(got), got,
                     $signed(exp), exp);
        end
    endtask

    // Reference: exact dot product of row coefficients and vector
    function automatic logic [63:0] model(input int row);
        longint s = 0;
        for (int k = 0; k < NCOL; k++) begin
            s += longint'(coef_mem[row*NCOL + k]) * longint'(vec[k]);
        end
        return s;
    endfunction

    // Monitor: compare every DUT write/done against the scoreboard
    always @(negedge clk) begin
        if (coef_rd) begin
            rd_count++;
            rd_cyc.push_back(cyc);
            rd_addr.push_back(coef_addr);
        end
        if (res_wr) begin
            wr_count++;
            last_wr_cyc = cyc;
            last_waddr  = res_waddr;
            last_wdata  = 64'($signed(res_wdata));
            if (exp_wr.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %0d, required no write",
                         res_waddr, $signed(res_wdata));
            end else begin
                mon_wr = exp_wr.pop_front();
                check("res_waddr", 64'(res_waddr), 64'(mon_wr.addr));
                check("res_wdata", 64'($signed(res_wdata)), mon_wr.data);
            end
        end
        if (done_row) begin
            done_count++;
            check("done_width", 64'(prev_done), 64'(0));
            if (exp_bad.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done_row 1, required 0");
            end else begin
                mon_bad = exp_bad.pop_front();
                check("bad_row", 64'(bad_row), 64'(mon_bad));
            end
        end else if (bad_row) begin
            n_checks++;
            n_fail++;
            $display("FAIL bad_without_done: bad_row 1 with done_row 0, required 0");
        end
        prev_done = done_row;
    end

    // Drive a row request at a negedge; returns T (the edge that samples it)
    task automatic issue(input int r, input bit expect_it, output int t);
        exp_wr_t e;
        res_add    = 4'(r);
        begin_mult = 1'b1;
        t          = cyc + 1;
        if (expect_it) begin
            if (r < NROW) begin
                e.addr = 4'(r);
                e.data = model(r);
                exp_wr.push_back(e);
            end
            exp_bad.push_back(r >= NROW);
        end
    endtask

    task automatic wait_done(input string name, output int seen);
        int n = 0;
        seen = -1;
        do begin
            @(negedge clk);
            n++;
        end while (done_row !== 1'b1 && n < 40);
        if (done_row === 1'b1) begin
            seen = cyc;
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: done_row 0 after 40 cycles, required 1", name);
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 128; i++) coef_mem[i] = DW'($urandom);
        for (int k = 0; k < NCOL; k++) vec[k] = DW'($urandom);
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'({coef_rd, coef_addr, res_wr, res_waddr, done_row, bad_row}), 64'(0));
        check({name, "_wdata"}, 64'(res_wdata), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100us, required finish");
        $fatal(1);
    end

    initial begin
        int t;
        int seen;
        int wr0, dn0, rd0;

        reset      = 1'b1;
        begin_mult = 1'b0;
        res_add    = '0;
        for (int i = 0; i < 128; i++) coef_mem[i] = '0;
        for (int k = 0; k < NCOL; k++) vec[k] = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        reset = 1'b0;
        @(negedge clk);

        // Row 0: coefficients 1, vector 1..8 -> 36; check read sequence and latency
        for (int k = 0; k < NCOL; k++) begin
            coef_mem[k] = 16'sd1;
            vec[k]      = DW'(k + 1);
        end
        rd_cyc.delete();
        rd_addr.delete();
        issue(0, 1'b1, t);
        wait_done("row0", seen);
        begin_mult = 1'b0;
        check("row0_done_time", 64'(seen + 1 - t), 64'(NCOL + 3));
        check("row0_write_time", 64'(last_wr_cyc + 1 - t), 64'(NCOL + 2));
        check("row0_wdata_36", last_wdata, 64'(36));
        check("row0_read_count", 64'(rd_cyc.size()), 64'(NCOL));
        for (int k = 0; k < NCOL && k < rd_cyc.size(); k++) begin
            check("row0_read_addr", 64'(rd_addr[k]), 64'(k));
            check("row0_read_cycle", 64'(rd_cyc[k]), 64'(t + k));
        end
        repeat (2) @(negedge clk);

        // Controller sequence, rows 0..9 with begin_mult held high
        fill_rand();
        wr0 = wr_count;
        dn0 = done_count;
        issue(0, 1'b1, t);
        for (int r = 0; r < NROW; r++) begin
            wait_done("seq", seen);
            if (r < NROW - 1) issue(r + 1, 1'b1, t);
        end
        begin_mult = 1'b0;
        repeat (3) @(negedge clk);
        check("seq_write_count", 64'(wr_count - wr0), 64'(NROW));
        check("seq_done_count", 64'(done_count - dn0), 64'(NROW));
        check("seq_last_waddr", 64'(last_waddr), 64'(NROW - 1));

        // Signed extremes: (-32768)*(-32768)*8 = 2^33
        for (int k = 0; k < NCOL; k++) begin
            coef_mem[2*NCOL + k] = -16'sd32768;
            coef_mem[4*NCOL + k] = 16'sd32767;
            vec[k]               = -16'sd32768;
        end
        issue(2, 1'b1, t);
        wait_done("extreme_pos", seen);
        begin_mult = 1'b0;
        @(negedge clk);
        check("extreme_pos_wdata", last_wdata, 64'h2_0000_0000);
        issue(4, 1'b1, t);
        wait_done("extreme_neg", seen);
        begin_mult = 1'b0;
        @(negedge clk);
        check("extreme_neg_wdata", last_wdata, -64'sd8589672448);

        // Illegal row: no reads, no write, done+bad at T+1
        rd0 = rd_count;
        wr0 = wr_count;
        issue(12, 1'b1, t);
        wait_done("bad_row", seen);
        begin_mult = 1'b0;
        check("bad_done_time", 64'(seen + 1 - t), 64'(1));
        check("bad_row_with_done", 64'(bad_row), 64'(1));
        repeat (3) @(negedge clk);
        check("bad_no_reads", 64'(rd_count - rd0), 64'(0));
        check("bad_no_write", 64'(wr_count - wr0), 64'(0));

        // Reset during the 4th RUN cycle aborts the row
        fill_rand();
        wr0 = wr_count;
        dn0 = done_count;
        issue(5, 1'b0, t);
        repeat (4) @(negedge clk);
        check("abort_in_run", 64'(coef_rd), 64'(1));
        reset      = 1'b1;
        begin_mult = 1'b0;
        @(negedge clk);
        check_all_zero("abort_outputs");
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_no_write", 64'(wr_count - wr0), 64'(0));
        check("abort_no_done", 64'(done_count - dn0), 64'(0));
        issue(3, 1'b1, t);
        wait_done("after_abort", seen);
        begin_mult = 1'b0;
        @(negedge clk);

        // res_add change and begin_mult drop mid-row are ignored
        fill_rand();
        issue(7, 1'b1, t);
        repeat (3) @(negedge clk);
        res_add    = 4'd1;
        begin_mult = 1'b0;
        wait_done("midrow", seen);
        @(negedge clk);
        check("midrow_waddr", 64'(last_waddr), 64'(7));

        // A few random rows
        for (int i = 0; i < 4; i++) begin
            fill_rand();
            issue(int'($urandom_range(0, NROW - 1)), 1'b1, t);
            wait_done("rand", seen);
            begin_mult = 1'b0;
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_writes_empty", 64'(exp_wr.size()), 64'(0));
        check("scoreboard_done_empty", 64'(exp_bad.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/row_mac_unit.md
Name: row_mac_unit

Overview:
- Responder side of the row-multiply handshake: consumes begin_mult/res_add from the main calculation controller and returns a one-cycle done_row per row.
- For each requested row it reads NCOL signed coefficients from the coefficient memory and forms their dot product with the held input vector.
- Writes the full-width result into the result buffer at address res_add.
- Sits between the main controller, the coefficient memory and the result buffer.

Parameters:
- NROW, 10: number of valid rows; res_add >= NROW is illegal.
- NCOL, 8: vector length and coefficients per row; power of two.
- DW, 16: signed coefficient and vector element width.
- ACCW, 2*DW+$clog2(NCOL) (35): accumulator and result width.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- begin_mult  in  1  row request; level, held high by controller until done_row.
- res_add  in  4  row index, valid while begin_mult=1.
- vec_data  in  NCOL*DW  packed signed vector; element k = bits [k*DW +: DW]; upstream holds it stable for the whole calculation.
- coef_rd  out  1  coefficient read strobe.
- coef_addr  out  4+$clog2(NCOL)  {row, col}.
- coef_rdata  in  DW  signed coefficient; valid exactly 1 cycle after coef_rd.
- res_wr  out  1  result write strobe (one cycle).
- res_waddr  out  4  result address (latched row).
- res_wdata  out  ACCW  signed dot product.
- done_row  out  1  one-cycle row-complete pulse to controller.
- bad_row  out  1  one-cycle pulse, concurrent with done_row, when row >= NROW.

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- All outputs are registered. Reset value of every output is 0.
- Reset also clears the state, col counter, accumulator and latched row.
- States are IDLE, RUN, DRAIN, WRITE, DONE.
- IDLE:
  - begin_mult=1 latches row=res_add and col=0, and clears the accumulator.
  - Goes to RUN if row < NROW, else DONE with bad_row set.
  - begin_mult=0 stays in IDLE.
- RUN (NCOL cycles):
  - coef_rd=1 and coef_addr={row,col}; col increments each cycle.
  - Each cycle after the first, acc += sign-extended(coef_rdata * vec_data[col-1]).
  - Goes to DRAIN once the read with col=NCOL-1 has been issued.
- DRAIN: coef_rd=0; accumulate the last product (col NCOL-1).
- WRITE: res_wr=1, res_waddr=row, res_wdata=acc.
- DONE: done_row=1 for exactly one cycle, then IDLE unconditionally.
  - This guarantees begin_mult is resampled only after the controller has advanced, so the same row is never re-triggered.
  - Back-to-back rows therefore restart from IDLE one cycle after done_row.
- Latency: begin_mult seen in IDLE at cycle T gives res_wr at T+NCOL+2 and done_row at T+NCOL+3 (T+11 for NCOL=8). Bad row: done_row at T+1.
- Arithmetic: signed DW x DW products, sign-extended to ACCW. Accumulation is exact and never overflows at ACCW.
- Boundaries:
  - begin_mult dropping or res_add changing mid-row is ignored; the row completes with the latched index.
  - reset mid-row aborts immediately: no res_wr, no done_row.
  - res_add changes while IDLE and begin_mult=0 have no effect.
  - A bad row issues no coef_rd and no res_wr.

Test Plan:
- Reset, then begin_mult=1, res_add=0, all coefficients 1, vec elements 1..8:
  - coef_addr 0..7 in consecutive cycles.
  - res_wr with wdata=36 at T+10.
  - done_row pulse at T+11, width 1.
- Controller-style sequence of rows 0..9 with begin_mult held high throughout:
  - exactly 10 res_wr and 10 done_row pulses.
  - res_waddr 0..9 in order; no row repeated.
- Signed extremes, all coefficients -32768 and all vec elements -32768:
  - wdata = 8*2^30 = 0x2_0000_0000 in 35 bits, no wrap.
  - Mixed +32767/-32768 gives exact negative sum.
- res_add=12 with begin_mult=1:
  - no coef_rd, no res_wr.
  - bad_row and done_row high together at T+1.
- Assert reset at the 4th RUN cycle:
  - all outputs 0 the next cycle, no write, no done_row.
  - a fresh row 3 afterwards computes correctly from a cleared accumulator.
- Change res_add and drop begin_mult mid-RUN: result is still written to the originally latched row with the correct value.
